// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-to-one memory arbiter: FSM states, requester
// identity and the latched memory request record.
package mem_arbiter_pkg;

  localparam int WIDTH    = 32;
  localparam int BE_WIDTH = WIDTH / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_SIDE_I = 1'b0,
    ARB_SIDE_D = 1'b1
  } arb_side_t;

  typedef struct packed {
    logic                read;
    logic                write;
    logic [BE_WIDTH-1:0] byte_enable;
    logic [WIDTH-1:0]    address;
    logic [WIDTH-1:0]    wdata;
  } mem_req_t;

  // Pack a requester's strobes into a request record. A side asserting read
  // and write together is illegal; it is resolved to a plain write so the
  // memory never sees both strobes at once.
  function automatic mem_req_t make_req(
    input logic                read,
    input logic                write,
    input logic [BE_WIDTH-1:0] byte_enable,
    input logic [WIDTH-1:0]    address,
    input logic [WIDTH-1:0]    wdata
  );
    mem_req_t r;
    r.read        = read & ~write;
    r.write       = write;
    r.byte_enable = byte_enable;
    r.address     = address;
    r.wdata       = wdata;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_req_latch.sv
// Holding register for the single outstanding memory request. Its contents
// drive the physical memory port directly, so clearing it drops the strobes.
module mem_req_latch
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  mem_req_t d,
  output mem_req_t q
);

  // Clear has priority over load; the arbiter never asserts both together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one round-robin arbiter merging the fetch port and the LSQ port onto
// one physical memory port, with one transaction outstanding at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [width/8-1:0]   i_mem_byte_enable,
  input  logic [width-1:0]     i_mem_address,
  input  logic [width-1:0]     i_mem_wdata,
  output logic                 i_mem_resp,
  output logic [width-1:0]     i_mem_rdata,

  input  logic                 lsq_mem_read,
  input  logic                 lsq_mem_write,
  input  logic [width/8-1:0]   lsq_mem_byte_enable,
  input  logic [width-1:0]     lsq_mem_address,
  input  logic [width-1:0]     lsq_mem_wdata,
  output logic                 lsq_mem_resp,
  output logic [width-1:0]     lsq_mem_rdata,

  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [width/8-1:0]   pmem_byte_enable,
  output logic [width-1:0]     pmem_address,
  output logic [width-1:0]     pmem_wdata,
  input  logic                 pmem_resp,
  input  logic [width-1:0]     pmem_rdata
);

  arb_state_t state;
  arb_side_t  last_grant;

  logic     req_i;
  logic     req_d;
  logic     grant_i;
  logic     grant_d;
  logic     idle;
  logic     busy;
  logic     load;
  logic     clear;
  mem_req_t req_in;
  mem_req_t req_q;

  assign idle = (state == ARB_IDLE);
  assign busy = (state == ARB_I) || (state == ARB_D);

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = lsq_mem_read | lsq_mem_write;

  // On a tie the side that did not win last time is served; after reset
  // last_grant points at the LSQ so the fetcher wins the first tie.
  assign grant_i = req_i & (~req_d | (last_grant == ARB_SIDE_D));
  assign grant_d = req_d & ~grant_i;

  // Requests are only sampled while idle; anything a side does while the
  // other is being served is invisible until the FSM comes back to idle.
  assign load  = idle & (grant_i | grant_d);
  assign clear = busy & pmem_resp;

  // Select the winning side's request for loading into the holding register.
  always_comb begin
    req_in = '0;
    if (grant_i) begin
      req_in = make_req(i_mem_read, i_mem_write, i_mem_byte_enable,
                        i_mem_address, i_mem_wdata);
    end else if (grant_d) begin
      req_in = make_req(lsq_mem_read, lsq_mem_write, lsq_mem_byte_enable,
                        lsq_mem_address, lsq_mem_wdata);
    end
  end

  mem_req_latch u_req_latch (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (clear),
    .d     (req_in),
    .q     (req_q)
  );

  // Arbitration FSM and round-robin history. A completed transaction always
  // passes through idle for one cycle before the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_SIDE_D;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_i) begin
            state      <= ARB_I;
            last_grant <= ARB_SIDE_I;
          end else if (grant_d) begin
            state      <= ARB_D;
            last_grant <= ARB_SIDE_D;
          end
        end
        ARB_I, ARB_D: begin
          if (pmem_resp) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // The physical port is a straight view of the holding register, so the
  // strobes vanish as soon as the register is reset or cleared.
  assign pmem_read        = req_q.read;
  assign pmem_write       = req_q.write;
  assign pmem_byte_enable = req_q.byte_enable;
  assign pmem_address     = req_q.address;
  assign pmem_wdata       = req_q.wdata;

  // Completion is steered by the current owner; a response arriving while
  // idle belongs to nobody and is dropped.
  assign i_mem_resp   = pmem_resp & (state == ARB_I);
  assign lsq_mem_resp = pmem_resp & (state == ARB_D);

  // Read data is shared; each requester qualifies it with its own resp.
  assign i_mem_rdata   = pmem_rdata;
  assign lsq_mem_rdata = pmem_rdata;

endmodule
